// File: rtl/alu_issue_if.sv
// Instruction and result handshake bundle between an issuer and the alu_issue stage.
interface alu_issue_if #(
  parameter int DW = 8,
  parameter int RW = 2
) ();
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [RW-1:0] in_rd;
  logic [RW-1:0] in_rs1;
  logic [RW-1:0] in_rs2;
  logic          in_imm_en;
  logic [DW-1:0] in_imm;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [RW-1:0] res_rd;
  logic          res_carry;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm, res_ready,
    input  in_ready, res_valid, res_data, res_rd, res_carry
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm, res_ready,
    output in_ready, res_valid, res_data, res_rd, res_carry
  );
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback stage around an external combinational alu: operand fetch from a
// small register file, one-cycle execute, result held until the consumer takes it.
//
// state | meaning
// IDLE  | ready for an instruction, operands latched on acceptance
// EXEC  | latched operands drive the alu, result written back at the closing edge
// RESP  | result presented, held until res_ready
module alu_issue #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int RW   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_issue_if.slave    io,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  output logic          carry_flag,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic [RW-1:0] res_rd_q, res_rd_d;
  logic          res_carry_q, res_carry_d;
  logic          carry_flag_q, carry_flag_d;
  logic          carry_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.in_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (io.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io.in_ready  = (state_q == IDLE);
    io.res_valid = (state_q == RESP);
    busy         = (state_q != IDLE);
  end

  // Writeback uses the latched rd, so rd==rs1/rs2 naturally sees the old value.
  always_comb begin
    rf_d         = rf_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rd_d         = rd_q;
    res_data_d   = res_data_q;
    res_rd_d     = res_rd_q;
    res_carry_d  = res_carry_q;
    carry_flag_d = carry_flag_q;
    carry_new    = (op_q == 3'd0) ? alu_carry : carry_flag_q;
    if (state_q == IDLE && io.in_valid) begin
      a_d  = rf_q[io.in_rs1];
      b_d  = io.in_imm_en ? io.in_imm : rf_q[io.in_rs2];
      op_d = io.in_op;
      rd_d = io.in_rd;
    end
    if (state_q == EXEC) begin
      rf_d[rd_q]   = alu_out;
      res_data_d   = alu_out;
      res_rd_d     = rd_q;
      carry_flag_d = carry_new;
      res_carry_d  = carry_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rd_q         <= '0;
      res_data_q   <= '0;
      res_rd_q     <= '0;
      res_carry_q  <= 1'b0;
      carry_flag_q <= 1'b0;
    end else begin
      rf_q         <= rf_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      res_data_q   <= res_data_d;
      res_rd_q     <= res_rd_d;
      res_carry_q  <= res_carry_d;
      carry_flag_q <= carry_flag_d;
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_op       = op_q;
  assign io.res_data  = res_data_q;
  assign io.res_rd    = res_rd_q;
  assign io.res_carry = res_carry_q;
  assign carry_flag   = carry_flag_q;
endmodule
